// File: rtl/s2p_deser.sv
// Serial-to-parallel deserializer with sof alignment, selectable bit order and valid/ready output.
// Define S2P_PARITY_EN to append an even-parity bit to each frame and report par_err with dout.
`timescale 1ns/1ps
module s2p_deser #(
  parameter int WIDTH     = 10,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_vld,
  input  logic             sof,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic             ovf,
  input  logic             ovf_clr,
  output logic             par_err
);

`ifdef S2P_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME + 1);
  localparam int IW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST  = CW'(FRAME - 1);
  localparam logic [CW-1:0] NDATA = CW'(WIDTH);
  localparam logic [IW-1:0] TOP   = IW'(WIDTH - 1);

  typedef enum logic {HUNT, SHIFT} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n, pos;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] shreg, shreg_n, dout_n;
  logic             dout_vld_n, ovf_n;
  logic             start, take, complete, load, drop;
`ifdef S2P_PARITY_EN
  logic             par, par_n, perr_q, perr_n;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= HUNT;
      cnt      <= '0;
      shreg    <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      ovf      <= 1'b0;
`ifdef S2P_PARITY_EN
      par      <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      shreg    <= shreg_n;
      dout     <= dout_n;
      dout_vld <= dout_vld_n;
      ovf      <= ovf_n;
`ifdef S2P_PARITY_EN
      par      <= par_n;
      perr_q   <= perr_n;
`endif
    end
  end

  // A qualified sof always restarts the frame, even mid-word in SHIFT.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    shreg_n    = shreg;
    dout_n     = dout;
    dout_vld_n = dout_vld;
    ovf_n      = ovf;
    complete   = 1'b0;
    start      = din_vld & sof;
    take       = din_vld & (sof | (state == SHIFT));
    pos        = start ? '0 : cnt;
    idx        = LSB_FIRST ? IW'(pos) : TOP - IW'(pos);
`ifdef S2P_PARITY_EN
    par_n      = par;
    perr_n     = perr_q;
`endif
    if (take) begin
      state_n = SHIFT;
      if (start) shreg_n = '0;
      if (pos < NDATA) shreg_n[idx] = din;
`ifdef S2P_PARITY_EN
      par_n = (start ? 1'b0 : par) ^ din;
`endif
      if (pos == LAST) begin
        complete = 1'b1;
        cnt_n    = '0;
      end else begin
        cnt_n = pos + CW'(1);
      end
    end

    // A finished word only displaces dout when the old one is gone or leaving now.
    load = complete & (~dout_vld | dout_rdy);
    drop = complete & dout_vld & ~dout_rdy;
    if (load) begin
      dout_n     = shreg_n;
      dout_vld_n = 1'b1;
`ifdef S2P_PARITY_EN
      perr_n     = par_n;
`endif
    end else if (dout_vld & dout_rdy) begin
      dout_vld_n = 1'b0;
    end
    if (ovf_clr) ovf_n = 1'b0;
    if (drop)    ovf_n = 1'b1;
  end

`ifdef S2P_PARITY_EN
  assign par_err = perr_q;
`else
  assign par_err = 1'b0;
`endif

endmodule
